// File: rtl/pcoeff_result_accumulator_pkg.sv
// Shared definitions for the pcoeff result accumulator: connect-count width,
// default range limit and the batch state encoding.
package pcoeff_result_accumulator_pkg;

  localparam int unsigned CONNECT_COUNT_WIDTH       = 6;
  localparam int unsigned MAX_CONNECT_COUNT_DEFAULT = 35;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAccum    = 2'd1,
    StComplete = 2'd2
  } accState_e;

endpackage

// File: rtl/pcoeff_result_accumulator_pow2_term_decoder.sv
// Stage S1: registers an accepted result and decodes its connect count into a
// one-hot 2^resultCount term. Counts above the legal maximum give a zero term
// and raise outOfRange.
module pcoeff_result_accumulator_pow2_term_decoder
  import pcoeff_result_accumulator_pkg::*;
#(
  parameter int unsigned SUM_WIDTH         = 48,
  parameter int unsigned MAX_CONNECT_COUNT = MAX_CONNECT_COUNT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           inValid,
  input  logic [CONNECT_COUNT_WIDTH-1:0] resultCount,
  output logic                           outValid,
  output logic [SUM_WIDTH-1:0]           term,
  output logic                           outOfRange
);

  logic                 rangeBad;
  logic [SUM_WIDTH-1:0] termD;

  // Decode the count; a shift past SUM_WIDTH naturally yields zero.
  always_comb begin
    rangeBad = 32'(resultCount) > MAX_CONNECT_COUNT;
    termD    = '0;
    if (!rangeBad) begin
      termD = {{(SUM_WIDTH-1){1'b0}}, 1'b1} << resultCount;
    end
  end

  // S1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid   <= 1'b0;
      term       <= '0;
      outOfRange <= 1'b0;
    end else begin
      outValid   <= inValid;
      term       <= termD;
      outOfRange <= inValid && rangeBad;
    end
  end

endmodule

// File: rtl/pcoeff_result_accumulator.sv
// Batch accumulator for the compute core's result stream: sums 2^resultCount
// over each announced batch and hands the sum and batch tag to the host FIFO
// through a single valid/ready output slot. Range, overflow and stray-result
// errors are sticky until reset.
module pcoeff_result_accumulator
  import pcoeff_result_accumulator_pkg::*;
#(
  parameter int unsigned EXTRA_DATA_WIDTH  = 14,
  parameter int unsigned COUNT_WIDTH       = 16,
  parameter int unsigned SUM_WIDTH         = 48,
  parameter int unsigned MAX_CONNECT_COUNT = MAX_CONNECT_COUNT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           batchStart,
  input  logic [COUNT_WIDTH-1:0]         batchExpected,
  input  logic [EXTRA_DATA_WIDTH-1:0]    batchTag,
  output logic                           batchStartReady,
  input  logic                           done,
  input  logic [CONNECT_COUNT_WIDTH-1:0] resultCount,
  input  logic [EXTRA_DATA_WIDTH-1:0]    extraDataIn,
  output logic                           sumValid,
  output logic [SUM_WIDTH-1:0]           sumOut,
  output logic [EXTRA_DATA_WIDTH-1:0]    sumTag,
  input  logic                           sumReady,
  output logic                           rangeError,
  output logic                           overflowError,
  output logic                           strayError,
  output logic [EXTRA_DATA_WIDTH-1:0]    strayTag
);

  logic [1:0]                  rstSyncQ;
  logic                        rstInt;
  accState_e                   stateQ, stateD;
  logic [COUNT_WIDTH-1:0]      expectedQ, issuedQ, receivedQ;
  logic [EXTRA_DATA_WIDTH-1:0] tagQ;
  logic [SUM_WIDTH-1:0]        accQ;
  logic                        s1Valid, s1OutOfRange;
  logic [SUM_WIDTH-1:0]        s1Term;
  logic [SUM_WIDTH:0]          addFull;
  logic                        accept, stray, startBatch, loadSlot;

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSyncQ <= 2'b00;
    end else begin
      rstSyncQ <= {rstSyncQ[0], 1'b1};
    end
  end
  assign rstInt = rstSyncQ[1];

  // issuedQ counts results already sent into S1, so anything past the last one is stray
  // even while earlier results are still in flight.
  assign accept          = done && (stateQ == StAccum) && (issuedQ != expectedQ);
  assign stray           = done && !accept;
  assign startBatch      = batchStart && (stateQ == StIdle);
  assign loadSlot        = (stateQ == StComplete) && (!sumValid || sumReady);
  assign addFull         = {1'b0, accQ} + {1'b0, s1Term};
  assign batchStartReady = (stateQ == StIdle);

  pcoeff_result_accumulator_pow2_term_decoder #(
    .SUM_WIDTH         (SUM_WIDTH),
    .MAX_CONNECT_COUNT (MAX_CONNECT_COUNT)
  ) u_decoder (
    .clk         (clk),
    .rst_n       (rstInt),
    .inValid     (accept),
    .resultCount (resultCount),
    .outValid    (s1Valid),
    .term        (s1Term),
    .outOfRange  (s1OutOfRange)
  );

  // Batch state machine: next state.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (batchStart) begin
          stateD = (batchExpected == '0) ? StComplete : StAccum;
        end
      end
      StAccum: begin
        if (receivedQ == expectedQ) begin
          stateD = StComplete;
        end
      end
      StComplete: begin
        if (loadSlot) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Batch bookkeeping and stage S2 accumulation.
  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      expectedQ <= '0;
      issuedQ   <= '0;
      receivedQ <= '0;
      tagQ      <= '0;
      accQ      <= '0;
    end else if (startBatch) begin
      expectedQ <= batchExpected;
      tagQ      <= batchTag;
      issuedQ   <= '0;
      receivedQ <= '0;
      accQ      <= '0;
    end else begin
      if (accept) begin
        issuedQ <= issuedQ + COUNT_WIDTH'(1);
      end
      if (s1Valid) begin
        accQ      <= addFull[SUM_WIDTH-1:0];
        receivedQ <= receivedQ + COUNT_WIDTH'(1);
      end
    end
  end

  // Sticky error flags; strayTag keeps the first offender only.
  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      rangeError    <= 1'b0;
      overflowError <= 1'b0;
      strayError    <= 1'b0;
      strayTag      <= '0;
    end else begin
      if (s1Valid && s1OutOfRange) begin
        rangeError <= 1'b1;
      end
      if (s1Valid && addFull[SUM_WIDTH]) begin
        overflowError <= 1'b1;
      end
      if (stray) begin
        strayError <= 1'b1;
        if (!strayError) begin
          strayTag <= extraDataIn;
        end
      end
    end
  end

  // Output slot: a load may coincide with the consumer draining the old entry.
  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      sumValid <= 1'b0;
      sumOut   <= '0;
      sumTag   <= '0;
    end else if (loadSlot) begin
      sumValid <= 1'b1;
      sumOut   <= accQ;
      sumTag   <= tagQ;
    end else if (sumValid && sumReady) begin
      sumValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcoeff_result_accumulator.sv
// Self-checking bench for pcoeff_result_accumulator. Two instances share the
// stimulus: a 48-bit sum and a 36-bit sum, the latter to exercise overflow.
module tb_pcoeff_result_accumulator;

  localparam int unsigned EW = 14;
  localparam int unsigned CW = 16;
  localparam logic [63:0] M48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [63:0] M36 = 64'h0000_000F_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          batchStart = 1'b0;
  logic [CW-1:0] batchExpected = '0;
  logic [EW-1:0] batchTag = '0;
  logic          done = 1'b0;
  logic [5:0]    resultCount = '0;
  logic [EW-1:0] extraDataIn = '0;
  logic          sumReady = 1'b1;

  logic          readyA, readyB, validA, validB;
  logic          rangeA, rangeB, ovfA, ovfB, strayA, strayB;
  logic [47:0]   sumA;
  logic [35:0]   sumB;
  logic [EW-1:0] tagA, tagB, sTagA, sTagB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcoeff_result_accumulator dutA (
    .clk (clk), .rst_n (rst_n), .batchStart (batchStart), .batchExpected (batchExpected),
    .batchTag (batchTag), .batchStartReady (readyA), .done (done), .resultCount (resultCount),
    .extraDataIn (extraDataIn), .sumValid (validA), .sumOut (sumA), .sumTag (tagA),
    .sumReady (sumReady), .rangeError (rangeA), .overflowError (ovfA), .strayError (strayA),
    .strayTag (sTagA)
  );

  pcoeff_result_accumulator #(.SUM_WIDTH (36)) dutB (
    .clk (clk), .rst_n (rst_n), .batchStart (batchStart), .batchExpected (batchExpected),
    .batchTag (batchTag), .batchStartReady (readyB), .done (done), .resultCount (resultCount),
    .extraDataIn (extraDataIn), .sumValid (validB), .sumOut (sumB), .sumTag (tagB),
    .sumReady (sumReady), .rangeError (rangeB), .overflowError (ovfB), .strayError (strayB),
    .strayTag (sTagB)
  );

  typedef struct {
    int          nExp;
    int          tag;
    int          rc0, rc1, rc2, rc3;
    logic [63:0] sumA;
    logic [63:0] sumB;
    bit          range;   // cumulative sticky expectations
    bit          ovfB;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic startBatch(input int nExp, input int tag);
    int n;
    n = 0;
    while (!readyA && n < 50) begin
      step();
      n++;
    end
    check("start_ready", 64'(readyA), 64'd1);
    batchExpected = CW'(nExp);
    batchTag      = EW'(tag);
    batchStart    = 1'b1;
    step();
    batchStart    = 1'b0;
  endtask

  task automatic sendResult(input int rc, input int tag);
    done        = 1'b1;
    resultCount = 6'(rc);
    extraDataIn = EW'(tag);
    step();
    done        = 1'b0;
  endtask

  task automatic waitSum(input string name, output int n);
    n = 0;
    while (!validA && n < 50) begin
      step();
      n++;
    end
    check({name, "_validA"}, 64'(validA), 64'd1);
    check({name, "_validB"}, 64'(validB), 64'd1);
  endtask

  initial begin
    int          lat;
    int          nExp, tag, rc;
    int          rcs[4];
    bit          holdReady, mRange, mOvfA, mOvfB;
    logic [63:0] total;

    vecs[0] = '{3, 5,      0,  1,  2,  0, 64'd7,            64'd7,           1'b0, 1'b0};
    vecs[1] = '{2, 1,      35, 35, 0,  0, 64'h10_0000_0000, 64'd0,           1'b0, 1'b1};
    vecs[2] = '{2, 2,      40, 3,  0,  0, 64'd8,            64'd8,           1'b1, 1'b1};
    vecs[3] = '{1, 3,      0,  0,  0,  0, 64'd1,            64'd1,           1'b1, 1'b1};
    vecs[4] = '{4, 16'h3fff, 10, 20, 30, 35, 64'h8_4010_0400, 64'h8_4010_0400, 1'b1, 1'b1};

    // Reset state.
    step();
    step();
    check("rst_ready", 64'(readyA), 64'd1);
    check("rst_valid", 64'(validA), 64'd0);
    check("rst_sum", 64'(sumA), 64'd0);
    check("rst_errs", 64'({rangeA, ovfA, strayA}), 64'd0);
    check("rst_strayTag", 64'(sTagA), 64'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // Table-driven batches, back-to-back results, consumer always ready.
    sumReady = 1'b1;
    foreach (vecs[v]) begin
      rcs = '{vecs[v].rc0, vecs[v].rc1, vecs[v].rc2, vecs[v].rc3};
      startBatch(vecs[v].nExp, vecs[v].tag);
      for (int i = 0; i < vecs[v].nExp; i++) sendResult(rcs[i], 0);
      waitSum("tbl", lat);
      check($sformatf("tbl%0d_sumA", v), 64'(sumA), vecs[v].sumA);
      check($sformatf("tbl%0d_sumB", v), 64'(sumB), vecs[v].sumB);
      check($sformatf("tbl%0d_tag", v), 64'(tagA), 64'(vecs[v].tag));
      check($sformatf("tbl%0d_readyAfterLoad", v), 64'(readyA), 64'd1);
      check($sformatf("tbl%0d_range", v), 64'(rangeA), 64'(vecs[v].range));
      check($sformatf("tbl%0d_ovfA", v), 64'(ovfA), 64'd0);
      check($sformatf("tbl%0d_ovfB", v), 64'(ovfB), 64'(vecs[v].ovfB));
      step();
      check($sformatf("tbl%0d_drained", v), 64'(validA), 64'd0);
    end

    // Reset in the middle of a batch: 1 of 4 results received.
    startBatch(4, 7);
    sendResult(0, 0);
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("mid_rst_ready", 64'(readyA), 64'd1);
    check("mid_rst_valid", 64'(validA), 64'd0);
    check("mid_rst_range", 64'(rangeA), 64'd0);
    check("mid_rst_ovfB", 64'(ovfB), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    startBatch(1, 8);
    sendResult(0, 0);
    waitSum("post_rst", lat);
    check("post_rst_sum", 64'(sumA), 64'd1);
    step();

    // Zero-length batch, then stray results while idle.
    startBatch(0, 11);
    waitSum("zero", lat);
    check("zero_latency", 64'(lat <= 3), 64'd1);
    check("zero_sum", 64'(sumA), 64'd0);
    check("zero_tag", 64'(tagA), 64'd11);
    step();
    sendResult(3, 9);
    check("idle_stray", 64'(strayA), 64'd1);
    check("idle_strayTag", 64'(sTagA), 64'd9);
    sendResult(3, 12);
    check("stray_first_kept", 64'(sTagA), 64'd9);
    startBatch(1, 4);
    sendResult(4, 0);
    waitSum("after_stray", lat);
    check("after_stray_sum", 64'(sumA), 64'd16);
    step();

    // A result past the last one of a batch is dropped and recorded.
    doReset();
    startBatch(2, 20);
    sendResult(1, 0);
    sendResult(1, 0);
    sendResult(5, 13);
    waitSum("late", lat);
    check("late_sum", 64'(sumA), 64'd4);
    check("late_stray", 64'(strayA), 64'd1);
    check("late_strayTag", 64'(sTagA), 64'd13);
    step();

    // Backpressure: batch B waits in COMPLETE behind undelivered batch A.
    sumReady = 1'b0;
    startBatch(1, 30);
    sendResult(2, 0);
    waitSum("bpA", lat);
    check("bpA_sum", 64'(sumA), 64'd4);
    startBatch(1, 31);
    sendResult(1, 0);
    repeat (6) step();
    check("bp_blocked_ready", 64'(readyA), 64'd0);
    check("bp_hold_valid", 64'(validA), 64'd1);
    check("bp_hold_sum", 64'(sumA), 64'd4);
    check("bp_hold_tag", 64'(tagA), 64'd30);
    sumReady = 1'b1;
    step();
    check("bpB_valid", 64'(validA), 64'd1);
    check("bpB_sum", 64'(sumA), 64'd2);
    check("bpB_tag", 64'(tagA), 64'd31);
    check("bpB_ready", 64'(readyA), 64'd1);
    step();
    check("bpB_drained", 64'(validA), 64'd0);

    // Randomised batches against the arithmetic model.
    doReset();
    mRange = 1'b0;
    mOvfA  = 1'b0;
    mOvfB  = 1'b0;
    for (int b = 0; b < 30; b++) begin
      nExp      = $urandom_range(1, 6);
      tag       = $urandom_range(0, 16383);
      holdReady = 1'($urandom_range(0, 1));
      total     = '0;
      sumReady  = !holdReady;
      startBatch(nExp, tag);
      for (int i = 0; i < nExp; i++) begin
        rc = ($urandom_range(0, 7) == 0) ? $urandom_range(36, 63) : $urandom_range(0, 35);
        if (rc <= 35) total += 64'd1 << rc;
        else mRange = 1'b1;
        sendResult(rc, i);
        if ($urandom_range(0, 1) == 1) step();
      end
      if (total >= (64'd1 << 48)) mOvfA = 1'b1;
      if (total >= (64'd1 << 36)) mOvfB = 1'b1;
      waitSum($sformatf("rnd%0d", b), lat);
      check($sformatf("rnd%0d_sumA", b), 64'(sumA), total & M48);
      check($sformatf("rnd%0d_sumB", b), 64'(sumB), total & M36);
      check($sformatf("rnd%0d_tag", b), 64'(tagA), 64'(tag));
      check($sformatf("rnd%0d_range", b), 64'(rangeA), 64'(mRange));
      check($sformatf("rnd%0d_ovfA", b), 64'(ovfA), 64'(mOvfA));
      check($sformatf("rnd%0d_ovfB", b), 64'(ovfB), 64'(mOvfB));
      check($sformatf("rnd%0d_stray", b), 64'(strayA), 64'd0);
      if (holdReady) begin
        repeat ($urandom_range(1, 3)) step();
        check($sformatf("rnd%0d_held", b), 64'(sumA), total & M48);
        sumReady = 1'b1;
      end
      step();
      check($sformatf("rnd%0d_drained", b), 64'(validA), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcoeff_result_accumulator.md
Name: pcoeff_result_accumulator

Overview:
- Sits directly downstream of the compute module and consumes its per-bot result stream (done, resultCount, extraDataOut).
- For each batch of bots sharing one top, it accumulates 2^resultCount over exactly the announced number of results.
- It then presents the batch sum plus the batch tag on a valid/ready output to the host-side result FIFO.
- It also flags range, overflow and protocol errors.

Parameters:
- EXTRA_DATA_WIDTH, 14, width of the per-result tag carried alongside each result.
- COUNT_WIDTH, 16, width of the expected-results counter per batch.
- SUM_WIDTH, 48, width of the accumulated sum.
- MAX_CONNECT_COUNT, 35, largest legal resultCount.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- batchStart  in  1  pulse: opens a new batch; only honoured when batchStartReady=1
- batchExpected  in  COUNT_WIDTH  number of results in the batch; sampled with batchStart
- batchTag  in  EXTRA_DATA_WIDTH  identifier returned with the sum; sampled with batchStart
- batchStartReady  out  1  high only in IDLE
- done  in  1  result strobe from the compute core; there is no backpressure
- resultCount  in  6  connect count, valid with done
- extraDataIn  in  EXTRA_DATA_WIDTH  per-result tag, valid with done; unused except for the stray-error capture
- sumValid  out  1  output slot holds a completed batch
- sumOut  out  SUM_WIDTH  completed batch sum
- sumTag  out  EXTRA_DATA_WIDTH  batchTag of the completed batch
- sumReady  in  1  consumer accepts when sumValid && sumReady
- rangeError  out  1  sticky: a resultCount > MAX_CONNECT_COUNT was seen
- overflowError  out  1  sticky: the sum carried out of SUM_WIDTH
- strayError  out  1  sticky: done arrived outside ACCUM
- strayTag  out  EXTRA_DATA_WIDTH  extraDataIn of the first stray result

Behaviour:
- Reset (async assert, sync deassert in the 2-FF synchroniser at top level): state=IDLE; all counters and sums = 0; sumValid=0; all sticky errors = 0; strayTag=0; batchStartReady=1 after reset.
- Pipeline:
  - S1 registers done/resultCount and decodes term = 1<<resultCount, zero-extended to SUM_WIDTH.
  - S2 adds term to the accumulator and increments the received counter.
  - Latency from done to accumulator update: 2 cycles.
  - One result is accepted per cycle, sustained; back-to-back done is legal.
- Range rule: resultCount > MAX_CONNECT_COUNT sets rangeError, contributes term=0 and still counts as received.
- Overflow rule: carry out of the S2 adder sets overflowError; the sum wraps modulo 2^SUM_WIDTH.
- State machine:
  - IDLE: on batchStart, latch expected and tag, clear accumulator and received counter, go to ACCUM. If batchExpected=0, go straight to COMPLETE with sum 0.
  - ACCUM: when the S2 update makes received == expected, go to COMPLETE on the next cycle. Any done arriving after the final result has entered S1 is stray: set strayError, drop the result, keep the count unchanged.
  - COMPLETE: if the output slot is free, or is being freed this cycle (sumValid && sumReady), load sumOut/sumTag, set sumValid, go to IDLE. Otherwise stay in COMPLETE.
- Stray results:
  - done while in IDLE or COMPLETE sets strayError and is ignored.
  - strayTag captures extraDataIn only on the first stray event.
- Output slot: sumValid stays high and sumOut/sumTag stay stable until the handshake completes. Simultaneous free and load in the same cycle is legal and gives no bubble.
- batchStart while batchStartReady=0 is ignored; this is not an error, because the producer must observe ready.
- The sticky errors clear only on reset.

Decomposition:
- Shared package header, pcoeff_defs.v:
  - CONNECT_COUNT_WIDTH = 6
  - MAX_CONNECT_COUNT default
  - state encodings IDLE = 2'd0, ACCUM = 2'd1, COMPLETE = 2'd2
- Sub-module pow2_term_decoder:
  - registered 6-bit to SUM_WIDTH one-hot decode with range check
  - outputs term and outOfRange
  - 1-cycle latency; this is stage S1

Test Plan:
- batchStart with expected=3, tag=5; results 0, 1, 2 on consecutive cycles -> sumValid=1, sumOut=7, sumTag=5; batchStartReady=1 on the cycle after the load.
- expected=2; results 35, 35 with SUM_WIDTH=48 -> sumOut=2^36, no errors. Repeat with SUM_WIDTH=36 -> overflowError=1 and sumOut=0.
- expected=0 -> sumValid=1 with sumOut=0 three cycles after batchStart; a done in IDLE with tag 9 -> strayError=1, strayTag=9, and the sum is unaffected.
- Hold sumReady=0; complete batch A (sum 4), then start and complete batch B (sum 2):
  - B waits in COMPLETE and batchStartReady=0.
  - Raise sumReady -> A is delivered, B loads the same cycle, then B is delivered.
- resultCount=40 within a 2-result batch with the other result = 3 -> rangeError=1, sumOut=8, and the batch completes.
- Assert rst_n low mid-ACCUM with 1 of 4 results received -> outputs clear immediately (asynchronously), state IDLE; a fresh batch of expected=1, result 0 gives sumOut=1.
